// File: rtl/emu_ctrl_sequencer_if.sv
// rtl/emu_ctrl_sequencer_if.sv - host command handshake bundle for emu_ctrl_sequencer
`ifndef TIME_WIDTH
`define TIME_WIDTH 16
`endif
`ifndef DT_WIDTH
`define DT_WIDTH 8
`endif

interface emu_ctrl_sequencer_if;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [1:0]               cmd_mode;
    logic [`TIME_WIDTH-1:0]   cmd_data;

    modport master (output cmd_valid, output cmd_mode, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_mode, input cmd_data, output cmd_ready);
endinterface

// File: rtl/emu_ctrl_sequencer.sv
// rtl/emu_ctrl_sequencer.sv - queued emulator run/stall/step command sequencer
// Optional CTRL_SEQ_REL_TIME_EN: mode-10 target becomes emu_time at pop + cmd_data (saturating).
`ifndef TIME_WIDTH
`define TIME_WIDTH 16
`endif
`ifndef DT_WIDTH
`define DT_WIDTH 8
`endif

module emu_ctrl_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                       emu_clk,
    input  logic                       emu_rst,
    emu_ctrl_sequencer_if.slave        cmd,
    input  logic                       ctrl_abort,
    input  logic [`TIME_WIDTH-1:0]     emu_time,
    input  logic [`DT_WIDTH-1:0]       emu_dt,
    output logic [1:0]                 emu_ctrl_mode,
    output logic [`TIME_WIDTH-1:0]     emu_ctrl_data,
    output logic                       cmd_done,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_level
);
    localparam int TW = `TIME_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t            state_q, state_d;
    logic [TW+1:0]     mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       level_q, level_d;
    logic [1:0]        cur_mode_q, cur_mode_d;
    logic [TW-1:0]     cur_data_q, cur_data_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic [1:0]        out_mode_q, out_mode_d;
    logic [TW-1:0]     out_data_q, out_data_d;
    logic              done_q, done_d;
    logic              push, pop, complete;
    logic [1:0]        head_mode;
    logic [TW-1:0]     head_data, load_data;

    assign cmd.cmd_ready = (level_q != FULL) && !ctrl_abort;
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    assign head_mode     = mem_q[rd_ptr_q][TW+1:TW];
    assign head_data     = mem_q[rd_ptr_q][TW-1:0];

`ifdef CTRL_SEQ_REL_TIME_EN
    logic [TW:0] rel_sum;
    assign rel_sum   = {1'b0, emu_time} + {1'b0, head_data};
    assign load_data = (head_mode == 2'b10) ? (rel_sum[TW] ? '1 : rel_sum[TW-1:0]) : head_data;
`else
    assign load_data = head_data;
`endif

    always_comb begin
        complete = 1'b0;
        case (cur_mode_q)
            2'b00:   complete = (level_q != '0);
            2'b01:   complete = (cnt_q[TW-1:1] == '0);
            2'b10:   complete = (emu_time >= cur_data_q);
            default: complete = (emu_dt != '0);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        done_d     = 1'b0;
        cur_mode_d = cur_mode_q;
        cur_data_d = cur_data_q;
        cnt_d      = cnt_q;
        if (ctrl_abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end
                end
                default: begin
                    if (complete) begin
                        done_d = 1'b1;
                        if (level_q != '0) pop = 1'b1;
                        else               state_d = IDLE;
                    end else if (cur_mode_q == 2'b01) begin
                        cnt_d = cnt_q - TW'(1);
                    end
                end
            endcase
        end
        if (pop) begin
            cur_mode_d = head_mode;
            cur_data_d = load_data;
            cnt_d      = head_data;
        end
        // Outputs trail the state register by one cycle; abort clears them immediately.
        if (state_q == EXEC && !ctrl_abort) begin
            out_mode_d = cur_mode_q;
            out_data_d = cur_data_q;
        end else begin
            out_mode_d = 2'b01;
            out_data_d = '0;
        end
        if (ctrl_abort)         level_d = '0;
        else if (push && !pop)  level_d = level_q + (AW+1)'(1);
        else if (pop && !push)  level_d = level_q - (AW+1)'(1);
        else                    level_d = level_q;
    end

    always_ff @(posedge emu_clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd.cmd_mode, cmd.cmd_data};
    end

    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            cur_mode_q <= 2'b01;
            cur_data_q <= '0;
            cnt_q      <= '0;
            out_mode_q <= 2'b01;
            out_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            cur_mode_q <= cur_mode_d;
            cur_data_q <= cur_data_d;
            cnt_q      <= cnt_d;
            out_mode_q <= out_mode_d;
            out_data_q <= out_data_d;
            done_q     <= done_d;
            if (ctrl_abort) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    assign emu_ctrl_mode = out_mode_q;
    assign emu_ctrl_data = out_data_q;
    assign cmd_done      = done_q;
    assign busy          = (state_q == EXEC);
    assign fifo_level    = level_q;
endmodule

// File: tb/tb_emu_ctrl_sequencer.sv
// tb/tb_emu_ctrl_sequencer.sv - directed self-checking bench for emu_ctrl_sequencer
`ifndef TIME_WIDTH
`define TIME_WIDTH 16
`endif
`ifndef DT_WIDTH
`define DT_WIDTH 8
`endif

module tb_emu_ctrl_sequencer;
    localparam int TW = `TIME_WIDTH;
    localparam int DW = `DT_WIDTH;
`ifdef CTRL_SEQ_REL_TIME_EN
    localparam int A_TGT  = 110;
    localparam int A_DONE = 11;
    localparam int F_DATA = 0;
`else
    localparam int A_TGT  = 100;
    localparam int A_DONE = 10;
    localparam int F_DATA = 20;
`endif

    logic            emu_clk = 1'b0;
    logic            emu_rst = 1'b1;
    logic            ctrl_abort;
    logic [TW-1:0]   emu_time;
    logic [DW-1:0]   emu_dt;
    logic [1:0]      emu_ctrl_mode;
    logic [TW-1:0]   emu_ctrl_data;
    logic            cmd_done;
    logic            busy;
    logic [2:0]      fifo_level;
    int              checks = 0;
    int              errors = 0;

    always #5 emu_clk = ~emu_clk;

    emu_ctrl_sequencer_if cmd_if ();

    emu_ctrl_sequencer #(.DEPTH(4)) dut (
        .emu_clk       (emu_clk),
        .emu_rst       (emu_rst),
        .cmd           (cmd_if.slave),
        .ctrl_abort    (ctrl_abort),
        .emu_time      (emu_time),
        .emu_dt        (emu_dt),
        .emu_ctrl_mode (emu_ctrl_mode),
        .emu_ctrl_data (emu_ctrl_data),
        .cmd_done      (cmd_done),
        .busy          (busy),
        .fifo_level    (fifo_level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge emu_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [TW-1:0] d);
        cmd_if.cmd_valid = v;
        cmd_if.cmd_mode  = m;
        cmd_if.cmd_data  = d;
    endtask

    initial begin
        int done_at;
        int pushed;
        int waited;
        int dones;
        ctrl_abort = 1'b0;
        emu_time   = '0;
        emu_dt     = '0;
        drive(1'b0, 2'b00, '0);

        // Reset values
        #12;
        check("rst_mode", 32'(emu_ctrl_mode), 1);
        check("rst_data", 32'(emu_ctrl_data), 0);
        check("rst_done", 32'(cmd_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_ready", 32'(cmd_if.cmd_ready), 1);
        step();
        emu_rst = 1'b0;
        step();

        // Run-to-time with emu_time ramping by 10 per cycle
        drive(1'b1, 2'b10, 16'd100);
        step();
        drive(1'b0, 2'b00, '0);
        emu_time = 16'd10;
        check("a_level", 32'(fifo_level), 1);
        check("a_mode_pre", 32'(emu_ctrl_mode), 1);
        done_at = 0;
        for (int k = 1; k <= 30 && done_at == 0; k++) begin
            step();
            emu_time = 16'(10 * (k + 1));
            if (k == 1) check("a_busy", 32'(busy), 1);
            if (k == 1) check("a_mode_lag", 32'(emu_ctrl_mode), 1);
            if (k == 2) check("a_mode", 32'(emu_ctrl_mode), 2);
            if (k == 2) check("a_data", 32'(emu_ctrl_data), 32'(A_TGT));
            if (cmd_done) done_at = k;
        end
        check("a_done_edge", done_at, A_DONE);
        check("a_busy_end", 32'(busy), 0);
        step();
        check("a_done_once", 32'(cmd_done), 0);
        check("a_mode_idle", 32'(emu_ctrl_mode), 1);
        check("a_data_idle", 32'(emu_ctrl_data), 0);

        // Stall 3 cycles
        drive(1'b1, 2'b01, 16'd3);
        step();
        drive(1'b0, 2'b00, '0);
        check("b_busy0", 32'(busy), 0);
        step();
        check("b_busy1", 32'(busy), 1);
        step();
        check("b_busy2", 32'(busy), 1);
        check("b_mode", 32'(emu_ctrl_mode), 1);
        step();
        check("b_busy3", 32'(busy), 1);
        check("b_nodone", 32'(cmd_done), 0);
        step();
        check("b_done", 32'(cmd_done), 1);
        check("b_idle", 32'(busy), 0);
        step();
        check("b_done_pulse", 32'(cmd_done), 0);

        // Free-run pre-empted by a single step, no bubble
        dones = 0;
        drive(1'b1, 2'b00, 16'd0);
        step();
        drive(1'b0, 2'b00, '0);
        for (int i = 0; i < 21; i++) begin
            step();
            if (cmd_done) dones++;
        end
        check("c_mode_free", 32'(emu_ctrl_mode), 0);
        drive(1'b1, 2'b11, 16'd5);
        emu_dt = 8'd5;
        step();
        drive(1'b0, 2'b00, '0);
        check("c_done_q0", 32'(cmd_done), 0);
        check("c_level_q0", 32'(fifo_level), 1);
        step();
        if (cmd_done) dones++;
        check("c_done_q1", 32'(cmd_done), 1);
        check("c_busy_q1", 32'(busy), 1);
        check("c_level_q1", 32'(fifo_level), 0);
        step();
        if (cmd_done) dones++;
        check("c_done_q2", 32'(cmd_done), 1);
        check("c_busy_q2", 32'(busy), 0);
        check("c_mode_q2", 32'(emu_ctrl_mode), 3);
        check("c_data_q2", 32'(emu_ctrl_data), 5);
        step();
        if (cmd_done) dones++;
        emu_dt = '0;
        check("c_dones", dones, 2);
        check("c_mode_q3", 32'(emu_ctrl_mode), 1);

        // FIFO full back-pressure during a long stall
        drive(1'b1, 2'b01, 16'd50);
        step();
        drive(1'b0, 2'b00, '0);
        step();
        check("d_busy", 32'(busy), 1);
        drive(1'b1, 2'b01, 16'd0);
        pushed = 0;
        for (int c = 0; c < 8 && pushed < 4; c++) begin
            if (cmd_if.cmd_ready) pushed++;
            step();
        end
        check("d_full_level", 32'(fifo_level), 4);
        check("d_full_ready", 32'(cmd_if.cmd_ready), 0);
        waited = 0;
        while (!cmd_if.cmd_ready && waited < 100) begin
            step();
            waited++;
        end
        check("d_ready_after_pop", 32'(cmd_if.cmd_ready), 1);
        check("d_level_after_pop", 32'(fifo_level), 3);
        step();
        drive(1'b0, 2'b00, '0);
        check("d_push_pop_level", 32'(fifo_level), 3);
        waited = 0;
        while (busy && waited < 20) begin
            step();
            waited++;
        end
        check("d_drained_busy", 32'(busy), 0);
        check("d_drained_level", 32'(fifo_level), 0);
        step();

        // Abort during run-to-time with 3 queued
        emu_time = 16'd5;
        drive(1'b1, 2'b10, 16'd60000);
        step();
        drive(1'b1, 2'b01, 16'd9);
        step();
        step();
        step();
        drive(1'b0, 2'b00, '0);
        check("e_level", 32'(fifo_level), 3);
        check("e_busy", 32'(busy), 1);
        ctrl_abort = 1'b1;
        drive(1'b1, 2'b00, 16'd1);
        #1;
        check("e_ready_abort", 32'(cmd_if.cmd_ready), 0);
        step();
        ctrl_abort = 1'b0;
        drive(1'b0, 2'b00, '0);
        check("e_busy_after", 32'(busy), 0);
        check("e_level_after", 32'(fifo_level), 0);
        check("e_done_after", 32'(cmd_done), 0);
        check("e_mode_after", 32'(emu_ctrl_mode), 1);
        step();
        check("e_level_hold", 32'(fifo_level), 0);
        check("e_done_hold", 32'(cmd_done), 0);
        check("e_busy_hold", 32'(busy), 0);

        // Target already reached completes after one EXEC cycle
        emu_time = 16'd50;
        drive(1'b1, 2'b10, 16'(F_DATA));
        step();
        drive(1'b0, 2'b00, '0);
        step();
        check("f_busy", 32'(busy), 1);
        step();
        check("f_done", 32'(cmd_done), 1);
        check("f_idle", 32'(busy), 0);
        step();

`ifdef CTRL_SEQ_REL_TIME_EN
        // Relative target formed at the pop edge
        emu_time = 16'd500;
        drive(1'b1, 2'b10, 16'd40);
        step();
        drive(1'b0, 2'b00, '0);
        step();
        step();
        check("g_data", 32'(emu_ctrl_data), 540);
        emu_time = 16'd539;
        step();
        check("g_nodone", 32'(cmd_done), 0);
        emu_time = 16'd540;
        step();
        check("g_done", 32'(cmd_done), 1);
        step();
`endif

        // Reset mid-command discards everything
        drive(1'b1, 2'b11, 16'd7);
        step();
        drive(1'b1, 2'b01, 16'd3);
        step();
        drive(1'b0, 2'b00, '0);
        step();
        check("r_mode_run", 32'(emu_ctrl_mode), 3);
        check("r_level_run", 32'(fifo_level), 1);
        #3;
        emu_rst = 1'b1;
        #1;
        check("r_busy", 32'(busy), 0);
        check("r_level", 32'(fifo_level), 0);
        check("r_mode", 32'(emu_ctrl_mode), 1);
        check("r_data", 32'(emu_ctrl_data), 0);
        check("r_done", 32'(cmd_done), 0);
        step();
        emu_rst = 1'b0;
        step();
        check("r_done_post", 32'(cmd_done), 0);
        check("r_busy_post", 32'(busy), 0);
        check("r_level_post", 32'(fifo_level), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/emu_ctrl_sequencer.md
EMU_CTRL_SEQUENCER -- requirements
Module: emu_ctrl_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth; power of two, at least 2.
REQ-002 Widths SHALL come from the `TIME_WIDTH and `DT_WIDTH macros.
REQ-003 emu_clk  in  1  the only clock; all logic on its rising edge.
REQ-004 emu_rst  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  host command offered.
REQ-006 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 cmd_mode  in  2  00 free-run, 01 stall N cycles, 10 run-to-time, 11 single step.
REQ-008 cmd_data  in  TIME_WIDTH  cycle count, target time or step size, depending on mode.
REQ-009 ctrl_abort  in  1  synchronous flush of the FIFO and the current command.
REQ-010 emu_time  in  TIME_WIDTH  current emulation time.
REQ-011 emu_dt  in  DT_WIDTH  timestep applied this cycle.
REQ-012 emu_ctrl_mode  out  2  registered control mode to the emulator controller.
REQ-013 emu_ctrl_data  out  TIME_WIDTH  registered control data to the emulator controller.
REQ-014 cmd_done  out  1  one-cycle pulse when a command completes.
REQ-015 busy  out  1  high while in EXEC.
REQ-016 fifo_level  out  $clog2(DEPTH)+1  number of queued commands.

Function
REQ-017 Push: when cmd_valid and cmd_ready are both high, {cmd_mode, cmd_data} SHALL be written to the FIFO.
REQ-018 cmd_ready SHALL equal (fifo_level != DEPTH) and !ctrl_abort.
REQ-019 FSM states: IDLE and EXEC.
REQ-020 In IDLE, emu_ctrl_mode SHALL be 01 and emu_ctrl_data SHALL be 0.
REQ-021 IDLE with the FIFO non-empty SHALL pop the head, load cur_mode/cur_data and go to EXEC.
  - emu_ctrl_mode/emu_ctrl_data reflect the new command from the next cycle.
  - A command pushed into an empty FIFO reaches the outputs 2 cycles after the push edge.
REQ-022 Completion conditions in EXEC:
  - 00: FIFO non-empty (pre-emption).
  - 01: down-counter loaded with cmd_data reaches 0; it decrements once per EXEC cycle; data 0 completes after 1 EXEC cycle.
  - 10: emu_time >= target (unsigned compare).
  - 11: first EXEC cycle with emu_dt != 0.
REQ-023 On completion, cmd_done SHALL pulse for exactly 1 cycle, and then:
  - if the FIFO is non-empty, the next command SHALL be popped on the same edge (no bubble) and the FSM stays in EXEC;
  - otherwise the FSM SHALL go to IDLE.
REQ-024 Mode 10 with target already <= emu_time SHALL complete after 1 EXEC cycle.
REQ-025 A push and a pop on the same edge SHALL leave fifo_level unchanged; the FIFO SHALL never overflow or underflow.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH.
REQ-027 ctrl_abort SHALL have highest priority:
  - flush the FIFO (level 0) and force IDLE on the next edge;
  - suppress cmd_done and drop any same-cycle push.
REQ-028 Mode 11 emu_ctrl_data SHALL carry cmd_data unmodified; saturation to the DT width is the downstream controller's job.

Reset
REQ-029 emu_rst high SHALL immediately force:
  - state IDLE, emu_ctrl_mode 01, emu_ctrl_data 0;
  - cmd_done 0, busy 0, fifo_level 0, counter 0.
REQ-030 Reset asserted mid-command SHALL discard the command and all queued entries without a cmd_done pulse.

Configuration
REQ-031 Macro CTRL_SEQ_REL_TIME_EN selects how a mode-10 target is formed.
  - Defined: target = emu_time at the pop edge + cmd_data, saturated to all-ones; emu_ctrl_data outputs this target.
  - Undefined: target = cmd_data (absolute time).

Verification
REQ-032 Push {10, 100} while idle, emu_time ramps by 10 per cycle from 0 -> mode 10 on the outputs 2 cycles after the push; cmd_done on the cycle after emu_time = 100; then mode 01.
REQ-033 Push {01, 3} -> emu_ctrl_mode = 01 for 3 EXEC cycles, busy high, then a single cmd_done.
REQ-034 Push {00, 0}, wait 20 cycles, push {11, 5} with emu_dt = 5 -> 00 completes on the push; mode 11 runs with no bubble and completes after 1 cycle; 2 cmd_done pulses total.
REQ-035 DEPTH = 4, push 5 commands back-to-back while a mode-01 command with data 50 executes -> cmd_ready low at fifo_level 4; the 5th is accepted only after a pop.
REQ-036 Assert ctrl_abort during mode 10 with 3 queued -> next cycle: IDLE, fifo_level 0, no cmd_done.
REQ-037 With CTRL_SEQ_REL_TIME_EN defined, emu_time = 500 at the pop, push {10, 40} -> emu_ctrl_data = 540; completion when emu_time >= 540.
